// File: rtl/rle_pkg.sv
// Shared definitions for the zero-run-length packer.
//   - default parameter values for the packer and its lane scanner
//   - header field offset helpers (count_lsb, last_bit)
//   - group_pack: builds one {value, run} group word
// No ports (package).
package rle_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_RUN_W  = 4;
    localparam int DEF_GROUPS = 5;
    localparam int DEF_LANES  = 16;

    // Group-count field sits directly above the group slots.
    function automatic int count_lsb(input int groups, input int gw);
        return groups * gw;
    endfunction

    // The last flag is the packet's top bit, above the count field.
    function automatic int last_bit(input int groups, input int gw, input int cnt_w);
        return groups * gw + cnt_w;
    endfunction

    // Run in the low run_w bits, value above it. The caller casts the
    // result down to its group width (group widths up to 64 bits).
    function automatic logic [63:0] group_pack(input int run_w, input logic [31:0] run,
                                               input logic [31:0] val);
        return ({32'd0, val} << run_w) | {32'd0, run};
    endfunction

endpackage

// File: rtl/rle_lane_scan.sv
// Combinational prefix scan over the input lanes.
// Walks lanes 0..in_num-1 in order, carrying the pending zero-run and the
// assembly slot count, and stops after the element that fills the last slot.
// Ports:
//   in_data    lane elements, lane 0 oldest
//   in_num     number of valid lanes
//   enable     0 blocks all taking (reset or assembly already full)
//   run_in     pending zero-run entering this cycle
//   cnt_in     assembly slot count entering this cycle
//   emit       per lane: this lane produces a group
//   lane_run   per lane: run field of the produced group
//   lane_slot  per lane: slot index of the produced group
//   take_num   lanes consumed this cycle
//   run_out    pending zero-run after the scan
//   cnt_out    slot count after the scan
module rle_lane_scan
    import rle_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RUN_W  = DEF_RUN_W,
    parameter int GROUPS = DEF_GROUPS,
    parameter int LANES  = DEF_LANES,
    localparam int CNT_W = $clog2(GROUPS + 1),
    localparam int NUM_W = $clog2(LANES + 1)
) (
    input  logic [LANES*DATA_W-1:0]       in_data,
    input  logic [NUM_W-1:0]              in_num,
    input  logic                          enable,
    input  logic [RUN_W-1:0]              run_in,
    input  logic [CNT_W-1:0]              cnt_in,
    output logic [LANES-1:0]              emit,
    output logic [LANES-1:0][RUN_W-1:0]   lane_run,
    output logic [LANES-1:0][CNT_W-1:0]   lane_slot,
    output logic [NUM_W-1:0]              take_num,
    output logic [RUN_W-1:0]              run_out,
    output logic [CNT_W-1:0]              cnt_out
);

    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    logic [RUN_W-1:0] run_c;
    logic [CNT_W-1:0] cnt_c;
    logic             stop_c;

    always_comb begin
        emit      = '0;
        lane_run  = '0;
        lane_slot = '0;
        take_num  = '0;
        run_c     = run_in;
        cnt_c     = cnt_in;
        stop_c    = !enable || (cnt_in == CNT_W'(GROUPS));
        for (int i = 0; i < LANES; i++) begin
            if (!stop_c && (NUM_W'(i) < in_num)) begin
                take_num = take_num + NUM_W'(1);
                // A saturated run is closed with a zero value; the lane's own
                // data is zero in that case, so both paths store in_data.
                if ((in_data[i*DATA_W +: DATA_W] != '0) || (run_c == RUN_MAX)) begin
                    emit[i]      = 1'b1;
                    lane_run[i]  = run_c;
                    lane_slot[i] = cnt_c;
                    cnt_c        = cnt_c + CNT_W'(1);
                    run_c        = '0;
                end else begin
                    run_c = run_c + RUN_W'(1);
                end
                if (cnt_c == CNT_W'(GROUPS)) begin
                    stop_c = 1'b1;
                end
            end
        end
        run_out = run_c;
        cnt_out = cnt_c;
    end

endmodule

// File: rtl/rle_zero_packer.sv
// Zero-run-length packer: turns a lane stream of elements into fixed-width
// packets of (zero-run, value) groups with a last flag for tile ends.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   in_data        LANES elements, lane 0 oldest
//   in_num         valid lanes counted from lane 0
//   in_flush       tile ends after the in_num elements
//   in_taken       elements consumed this cycle (combinational)
//   in_flush_ack   flush accepted this cycle (combinational)
//   out_data       packet: groups, count, last
//   out_valid      packet valid
//   out_ready      downstream accepts
// Handshake: a packet transfers on a rising edge where out_valid and
// out_ready are both high; out_data/out_valid hold while out_valid && !out_ready.
module rle_zero_packer
    import rle_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RUN_W  = DEF_RUN_W,
    parameter int GROUPS = DEF_GROUPS,
    parameter int LANES  = DEF_LANES,
    localparam int GW    = RUN_W + DATA_W,
    localparam int CNT_W = $clog2(GROUPS + 1),
    localparam int OUT_W = GROUPS * GW + CNT_W + 1,
    localparam int NUM_W = $clog2(LANES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [NUM_W-1:0]        in_num,
    input  logic                    in_flush,
    output logic [NUM_W-1:0]        in_taken,
    output logic                    in_flush_ack,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int CNT_LSB  = count_lsb(GROUPS, GW);
    localparam int LAST_BIT = last_bit(GROUPS, GW, CNT_W);

    logic [GROUPS-1:0][GW-1:0] slots_q, slots_d, slots_a, slots_f;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_a, cnt_f;
    logic [RUN_W-1:0]          run_q, run_d, run_a;
    logic [OUT_W-1:0]          out_data_q, out_data_d, pkt;
    logic                      out_valid_q, out_valid_d;

    logic [LANES-1:0]            emit;
    logic [LANES-1:0][RUN_W-1:0] lane_run;
    logic [LANES-1:0][CNT_W-1:0] lane_slot;
    logic [NUM_W-1:0]            take_num;
    logic                        out_free, flush_ok, send;

    // A full assembly blocks input until it moves to the output register.
    rle_lane_scan #(
        .DATA_W(DATA_W), .RUN_W(RUN_W), .GROUPS(GROUPS), .LANES(LANES)
    ) u_scan (
        .in_data   (in_data),
        .in_num    (in_num),
        .enable    (rst_n && (cnt_q != CNT_W'(GROUPS))),
        .run_in    (run_q),
        .cnt_in    (cnt_q),
        .emit      (emit),
        .lane_run  (lane_run),
        .lane_slot (lane_slot),
        .take_num  (take_num),
        .run_out   (run_a),
        .cnt_out   (cnt_a)
    );

    always_comb begin
        out_free = !out_valid_q || out_ready;

        // Assembly after this cycle's lanes.
        slots_a = slots_q;
        for (int i = 0; i < LANES; i++) begin
            for (int g = 0; g < GROUPS; g++) begin
                if (emit[i] && (lane_slot[i] == CNT_W'(g))) begin
                    slots_a[g] = GW'(group_pack(RUN_W, 32'(lane_run[i]),
                                                32'(in_data[i*DATA_W +: DATA_W])));
                end
            end
        end

        // A trailing run needs one free slot for its closing (run-1, 0) group.
        flush_ok = rst_n && in_flush && (take_num == in_num) && out_free &&
                   ((run_a == '0) || (cnt_a != CNT_W'(GROUPS)));

        slots_f = slots_a;
        cnt_f   = cnt_a;
        if (flush_ok && (run_a != '0)) begin
            for (int g = 0; g < GROUPS; g++) begin
                if (cnt_a == CNT_W'(g)) begin
                    slots_f[g] = GW'(group_pack(RUN_W, 32'(run_a - RUN_W'(1)), 32'd0));
                end
            end
            cnt_f = cnt_a + CNT_W'(1);
        end

        send = flush_ok || ((cnt_a == CNT_W'(GROUPS)) && out_free);

        pkt = '0;
        for (int g = 0; g < GROUPS; g++) begin
            pkt[g*GW +: GW] = slots_f[g];
        end
        pkt[CNT_LSB +: CNT_W] = cnt_f;
        pkt[LAST_BIT]         = flush_ok;

        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        slots_d     = slots_a;
        cnt_d       = cnt_a;
        run_d       = run_a;
        if (send) begin
            out_data_d  = pkt;
            out_valid_d = 1'b1;
            slots_d     = '0;
            cnt_d       = '0;
            run_d       = flush_ok ? '0 : run_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slots_q     <= '0;
            cnt_q       <= '0;
            run_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            slots_q     <= slots_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_taken     = take_num;
    assign in_flush_ack = flush_ok;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_rle_zero_packer.sv
module tb_rle_zero_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_data;
    logic [4:0]   in_num;
    logic         in_flush;
    logic [4:0]   in_taken;
    logic         in_flush_ack;
    logic [63:0]  out_data;
    logic         out_valid;
    logic         out_ready;

    logic [63:0] exp_q[$];
    logic [7:0]  src[$];
    int          n_total = 0;
    int          n_bad   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    rle_zero_packer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_num       (in_num),
        .in_flush     (in_flush),
        .in_taken     (in_taken),
        .in_flush_ack (in_flush_ack),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] grp(input int r, input int v);
        return {v[7:0], r[3:0]};
    endfunction

    function automatic logic [63:0] pkt(input logic last, input int cnt,
                                        input logic [11:0] g0, input logic [11:0] g1,
                                        input logic [11:0] g2, input logic [11:0] g3,
                                        input logic [11:0] g4);
        return {last, cnt[2:0], g4, g3, g2, g1, g0};
    endfunction

    // Scoreboard: every accepted packet must match the head of exp_q.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("pkt_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("pkt_data", out_data, exp_q.pop_front());
        end
    end

    // ---------------- drivers ----------------
    // One cycle of upstream: present up to 16 queued elements, check the
    // combinational take/ack, then shift the queue by what was taken.
    task automatic step(input int exp_taken, input bit flush, input bit exp_ack,
                        input bit rdy, input string tag);
        int n;
        @(posedge clk);
        #1;
        n = (src.size() > 16) ? 16 : src.size();
        in_num    = 5'(n);
        in_flush  = flush;
        out_ready = rdy;
        in_data   = '0;
        for (int i = 0; i < n; i++) in_data[i*8 +: 8] = src[i];
        @(negedge clk);
        check({tag, "_taken"}, 64'(in_taken), 64'(exp_taken));
        check({tag, "_ack"}, 64'(in_flush_ack), 64'(exp_ack));
        for (int i = 0; i < int'(in_taken); i++) begin
            if (src.size() != 0) void'(src.pop_front());
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            in_num   = '0;
            in_flush = 1'b0;
            in_data  = '0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_data   = 128'h0500_0007;
        in_num    = 5'd4;
        in_flush  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_taken", 64'(in_taken), 64'd0);
        check("rst_ack", 64'(in_flush_ack), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_num = '0;
        in_flush = 1'b0;
        in_data = '0;
        idle(1);

        // Basic flush with mixed data.
        src = '{8'd5, 8'd0, 8'd0, 8'd7};
        exp_q.push_back(pkt(1'b1, 2, grp(0, 5), grp(2, 7), 12'd0, 12'd0, 12'd0));
        step(4, 1'b1, 1'b1, 1'b1, "t1");
        idle(1);
        @(negedge clk);
        check("t1_latency_valid", 64'(out_valid), 64'd1);
        idle(2);

        // Saturating run: 20 zeros then 3.
        src = {};
        repeat (20) src.push_back(8'd0);
        src.push_back(8'd3);
        exp_q.push_back(pkt(1'b1, 2, grp(15, 0), grp(4, 3), 12'd0, 12'd0, 12'd0));
        step(16, 1'b0, 1'b0, 1'b1, "t2a");
        step(5, 1'b1, 1'b1, 1'b1, "t2b");
        idle(2);

        // Values 1..16: three full packets then a flushed single group.
        src = {};
        for (int i = 1; i <= 16; i++) src.push_back(8'(i));
        exp_q.push_back(pkt(1'b0, 5, grp(0, 1), grp(0, 2), grp(0, 3), grp(0, 4), grp(0, 5)));
        exp_q.push_back(pkt(1'b0, 5, grp(0, 6), grp(0, 7), grp(0, 8), grp(0, 9), grp(0, 10)));
        exp_q.push_back(pkt(1'b0, 5, grp(0, 11), grp(0, 12), grp(0, 13), grp(0, 14), grp(0, 15)));
        exp_q.push_back(pkt(1'b1, 1, grp(0, 16), 12'd0, 12'd0, 12'd0, 12'd0));
        step(5, 1'b0, 1'b0, 1'b1, "t3a");
        step(5, 1'b0, 1'b0, 1'b1, "t3b");
        step(5, 1'b0, 1'b0, 1'b1, "t3c");
        step(1, 1'b1, 1'b1, 1'b1, "t3d");
        idle(2);

        // Trailing zeros only, then an empty flush.
        src = '{8'd0, 8'd0, 8'd0};
        exp_q.push_back(pkt(1'b1, 1, grp(2, 0), 12'd0, 12'd0, 12'd0, 12'd0));
        exp_q.push_back(pkt(1'b1, 0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0));
        step(3, 1'b1, 1'b1, 1'b1, "t4");
        step(0, 1'b1, 1'b1, 1'b1, "t4e");
        idle(2);

        // Back-pressure: second assembly fills while first packet waits.
        src = {};
        for (int i = 1; i <= 12; i++) src.push_back(8'(i));
        exp_q.push_back(pkt(1'b0, 5, grp(0, 1), grp(0, 2), grp(0, 3), grp(0, 4), grp(0, 5)));
        exp_q.push_back(pkt(1'b0, 5, grp(0, 6), grp(0, 7), grp(0, 8), grp(0, 9), grp(0, 10)));
        exp_q.push_back(pkt(1'b1, 2, grp(0, 11), grp(0, 12), 12'd0, 12'd0, 12'd0));
        step(5, 1'b0, 1'b0, 1'b0, "t5a");
        step(5, 1'b0, 1'b0, 1'b0, "t5b");
        step(0, 1'b0, 1'b0, 1'b0, "t5c");
        check("t5c_hold_valid", 64'(out_valid), 64'd1);
        check("t5c_hold_data", out_data,
              pkt(1'b0, 5, grp(0, 1), grp(0, 2), grp(0, 3), grp(0, 4), grp(0, 5)));
        step(0, 1'b1, 1'b0, 1'b0, "t5d");
        check("t5d_hold_data", out_data,
              pkt(1'b0, 5, grp(0, 1), grp(0, 2), grp(0, 3), grp(0, 4), grp(0, 5)));
        step(0, 1'b0, 1'b0, 1'b1, "t5e");
        step(2, 1'b1, 1'b1, 1'b1, "t5f");
        idle(3);

        // Reset with a partial assembly: nothing emitted, then empty flush.
        src = '{8'd1, 8'd2, 8'd3};
        step(3, 1'b0, 1'b0, 1'b1, "t6");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_num = '0;
        in_data = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        exp_q.push_back(pkt(1'b1, 0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0));
        step(0, 1'b1, 1'b1, 1'b1, "t6f");
        idle(3);
        @(negedge clk);
        check("drained", 64'(exp_q.size()), 64'd0);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rle_zero_packer.md
# rle_zero_packer

Parametrised zero-run-length packer for output-map data, sitting between the PE-array output buffer and the memory write path. Each cycle it scans up to LANES candidate elements and takes as many as fit into the current packet. It encodes them as (zero-run, value) groups and emits fixed-width packets over a valid/ready handshake. Generalises the fixed 16×8-bit / 5-group / 64-bit packer with configurable widths, saturating-run encoding, explicit tile flush and full back-pressure.

## Interface
- DATA_W, 8, element width
- RUN_W, 4, zero-run field width; RUN_MAX = 2^RUN_W−1
- GROUPS, 5, groups per packet
- LANES, 16, input lanes per cycle
- Derived: GW = RUN_W+DATA_W; CNT_W = $clog2(GROUPS+1); OUT_W = GROUPS·GW+CNT_W+1 (64 at defaults)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- in_data  in  LANES×DATA_W  candidate elements, lane 0 oldest
- in_num  in  $clog2(LANES+1)  valid lanes, counted from lane 0 (0..LANES)
- in_flush  in  1  tile ends after the in_num elements
- in_taken  out  $clog2(LANES+1)  elements consumed this cycle (combinational); upstream shifts by this amount
- in_flush_ack  out  1  flush accepted this cycle (combinational)
- out_data  out  OUT_W  packet
- out_valid  out  1  packet valid
- out_ready  in  1  downstream accepts

## Operation
- Group (r,v) means r zeros followed by value v. Groups fill slots 0..GROUPS−1 in order. Slot g occupies bits [g·GW +: GW]: run in the low RUN_W bits, value above. Unused slots are 0.
- Header: bit OUT_W−1 = last; bits [OUT_W−2 -: CNT_W] = number of valid groups.
- State: assembly packet (slots plus slot count) and a pending zero-run counter `run`, both persisting across cycles and packets.
- Lane scan in order, lane i < in_num:
  - Nonzero value → emit (run,v), run←0.
  - Zero with run<RUN_MAX → run++.
  - Zero with run==RUN_MAX → emit (RUN_MAX,0), run←0. This covers RUN_MAX+1 zeros.
- Taking stops after the element whose group fills slot GROUPS−1. Later lanes are not taken that cycle.
- Assembly full and output slot busy: in_taken=0 until the packet moves.
- Output slot is free when !out_valid || out_ready. A packet completed or held full moves to out_data at the edge when the slot is free; the assembly clears on that edge.
- Flush is accepted only when in_flush, in_taken==in_num, output slot free, and a slot is available if run>0. On acceptance:
  - run>0 → append (run−1,0).
  - Send the packet with last=1. This includes count=0 when nothing is pending.
  - Clear run; pulse in_flush_ack.
- Flush not accepted → upstream holds in_flush (in_num may be 0) until it is.
- At most one packet completes per cycle.

## Timing
- Reset: out_valid=0, out_data=0, run=0, assembly empty. in_taken=0 and in_flush_ack=0 while rst_n=0.
- Latency: an element that completes a packet in cycle N appears in out_data from N+1.
- out_data and out_valid are registered. They stay stable while out_valid && !out_ready.
- The assembly may refill while a packet waits in the output register. Only the full-assembly state blocks input.
- Reset mid-packet: the partial packet and run are discarded, with no output.

## Structure
- Package rle_pkg: default parameter constants, header field offset functions (count_lsb, last_bit), and a `group_pack` function.
- Sub-module rle_lane_scan: combinational prefix scan over lanes. Produces per-lane emit flags, run values, slot indices and the take cutoff.
- Top: state registers, flush control, output register.

## Test plan
- in_num=4 {5,0,0,7}, in_flush=1, out_ready=1 → in_taken=4, ack; next cycle packet slot0=(0,5), slot1=(2,7), count=2, last=1.
- 20 zeros then 3, flush → groups (15,0) and (4,3), count=2, last=1.
- 16 nonzero values 1..16 fed by in_taken: in_taken 5,5,5 then 1 with flush. Expect three full packets (count=5, last=0) and a final packet (0,16) with count=1, last=1.
- 3 zeros then flush → single group (2,0), count=1, last=1. Flush with nothing pending → count=0, last=1 packet.
- out_ready=0 with two packets' worth of data → second assembly fills, in_taken=0, out_data stable. out_ready=1 → the held packet transfers next edge and input resumes.
- Assert rst_n=0 for one cycle with 3 groups assembled → out_valid=0, no packet emitted. A subsequent flush yields count=0, last=1.
